// File: rtl/shifter_pkg.sv
// Shared shifter types: operation encoding and sequencer state.
package shifter_pkg;

  // Shift operation as carried on the op port.
  typedef enum logic [1:0] {
    OP_LSL = 2'b00,
    OP_LSR = 2'b01,
    OP_ASR = 2'b10,
    OP_ROR = 2'b11
  } shift_op_t;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift of a word; out_bit is the bit that leaves the word.
module shift_step
  import shifter_pkg::*;
#(
  parameter int data_width = 16
) (
  input  logic [data_width-1:0] word_i,
  input  shift_op_t             op_i,
  output logic [data_width-1:0] word_o,
  output logic                  bit_o
);

  // Select the single-step result for the requested operation.
  always_comb begin
    word_o = word_i;
    bit_o  = 1'b0;
    case (op_i)
      OP_LSL: begin
        word_o = {word_i[data_width-2:0], 1'b0};
        bit_o  = word_i[data_width-1];
      end
      OP_LSR: begin
        word_o = {1'b0, word_i[data_width-1:1]};
        bit_o  = word_i[0];
      end
      OP_ASR: begin
        word_o = {word_i[data_width-1], word_i[data_width-1:1]};
        bit_o  = word_i[0];
      end
      OP_ROR: begin
        word_o = {word_i[0], word_i[data_width-1:1]};
        bit_o  = word_i[0];
      end
      default: begin
        word_o = word_i;
        bit_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: one bit position per cycle, valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and the
// result stays stable in DONE until out_ready is seen high.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int data_width = 16,
  parameter int amt_width  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [data_width-1:0] in,
  input  logic [1:0]            op,
  input  logic [amt_width-1:0]  amount,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [data_width-1:0] sout,
  output logic                  cout,
  output logic                  busy,
  output state_t                dbg_state
);

  localparam logic [amt_width-1:0] CNT_ONE = {{(amt_width-1){1'b0}}, 1'b1};

  state_t                state_q, state_d;
  logic [data_width-1:0] work_q, work_d;
  shift_op_t             op_q, op_d;
  logic [amt_width-1:0]  cnt_q, cnt_d;
  logic                  cout_q, cout_d;

  logic [data_width-1:0] step_word;
  logic                  step_bit;

  shift_step #(.data_width(data_width)) u_step (
    .word_i (work_q),
    .op_i   (op_q),
    .word_o (step_word),
    .bit_o  (step_bit)
  );

  // Next-state and datapath update; the counter holds remaining steps.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in;
          op_d    = shift_op_t'(op);
          cnt_d   = amount;
          cout_d  = 1'b0;
          state_d = (amount == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = step_word;
        cout_d = step_bit;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        // No accept here: the next request waits for IDLE.
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      op_q    <= OP_LSL;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign sout      = work_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Self-checking bench for seq_shifter with an expected-result queue.
module tb_seq_shifter;
  import shifter_pkg::*;

  localparam int W  = 16;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    op_in;
  logic [AW-1:0] amount;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sout;
  logic          cout;
  logic          busy;
  state_t        dbg_state;

  seq_shifter #(.data_width(W), .amt_width(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .op        (op_in),
    .amount    (amount),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sout      (sout),
    .cout      (cout),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [W:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: {cout, result} of shifting d by n positions
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [1:0] o, input int n);
    logic [W-1:0] r;
    logic         c;
    if (n == 0) return {1'b0, d};
    case (o)
      2'd0: begin r = d << n; c = d[W-n]; end
      2'd1: begin r = d >> n; c = d[n-1]; end
      2'd2: begin r = $signed(d) >>> n; c = d[n-1]; end
      default: begin r = (d >> n) | (d << (W-n)); c = d[n-1]; end
    endcase
    return {c, r};
  endfunction

  // driver: one request, latency check, optional hold in DONE, scoreboard pop
  task automatic run_req(input logic [W-1:0] d, input logic [1:0] o, input int n,
                         input logic [W:0] exp, input int hold, input bit noise);
    int lat;
    int guard;
    logic [W:0] held;
    logic [W:0] want;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_val("ready_before_req", in_ready, 1);
    in_data  = d;
    op_in    = o;
    amount   = n[AW-1:0];
    in_valid = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 64) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = W'($urandom);
        op_in    = 2'($urandom_range(0, 3));
        amount   = AW'($urandom_range(0, 15));
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check_val("latency", lat, n + 1);
    check_val("done_in_ready", in_ready, 0);
    check_val("done_busy", busy, 1);
    held = {cout, sout};
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("hold_valid", out_valid, 1);
      check_val("hold_stable", {cout, sout}, held);
    end
    if (exp_q.size() == 0) begin
      check_val("queue_empty", 1, 0);
    end else begin
      want = exp_q.pop_front();
      check_val("sout", sout, want[W-1:0]);
      check_val("cout", cout, want[W]);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_val("post_out_valid", out_valid, 0);
    check_val("post_in_ready", in_ready, 1);
    check_val("post_busy", busy, 0);
  endtask

  initial begin
    logic [W-1:0] rd;
    logic [1:0]   ro;
    int           rn;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    op_in     = 2'd0;
    amount    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_sout", sout, 0);
    check_val("rst_cout", cout, 0);
    check_val("rst_state", dbg_state, ST_IDLE);

    // directed cases with fixed expected values
    run_req(16'hF0CF, 2'd0, 0,  {1'b0, 16'hF0CF}, 0, 1'b0);
    run_req(16'hF0CF, 2'd0, 1,  {1'b1, 16'hE19E}, 0, 1'b0);
    run_req(16'hF0CF, 2'd1, 1,  {1'b1, 16'h7867}, 0, 1'b0);
    run_req(16'hF0CF, 2'd2, 1,  {1'b1, 16'hF867}, 0, 1'b0);
    run_req(16'h8001, 2'd3, 4,  {1'b0, 16'h1800}, 0, 1'b0);
    run_req(16'h8000, 2'd2, 15, {1'b0, 16'hFFFF}, 0, 1'b1);
    run_req(16'h8000, 2'd1, 15, {1'b0, 16'h0001}, 3, 1'b1);
    run_req(16'h1234, 2'd3, 15, {1'b0, 16'h2468}, 0, 1'b0);

    // random requests checked against the reference
    for (int k = 0; k < 8; k++) begin
      rd = W'($urandom);
      ro = 2'($urandom_range(0, 3));
      rn = $urandom_range(0, 15);
      run_req(rd, ro, rn, model(rd, ro, rn), $urandom_range(0, 2), 1'b1);
    end

    // reset in the middle of SHIFT aborts with no result
    @(negedge clk);
    in_data  = 16'hA5A5;
    op_in    = 2'd3;
    amount   = 4'd10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("mid_shift_state", dbg_state, ST_SHIFT);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_state", dbg_state, ST_IDLE);
    check_val("abort_out_valid", out_valid, 0);
    check_val("abort_in_ready", in_ready, 1);
    check_val("abort_sout", sout, 0);
    check_val("abort_cout", cout, 0);
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      check_val("abort_no_result", out_valid, 0);
    end

    check_val("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
